// File: rtl/pipelined_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
// The WIDTH-bit operation is cut into STAGES equal segments. Segment k is
// summed in pipeline stage k using the registered carry of segment k-1, so
// operands are skewed on the way in and partial results are delayed on the
// way out until every segment of one operation lines up at the output.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             stall,
    input  logic [1:0]       op,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             carry_out,
    output logic             overflow,
    output logic             data_resultRDY
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int NGRP = (SEG + 3) / 4;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_PASS = 2'b10,
        OP_ADC  = 2'b11
    } op_t;

    op_t               op_sel;
    logic [WIDTH-1:0]  a_eff;
    logic [WIDTH-1:0]  b_eff;
    logic              c0;
    logic [STAGES-1:0] valid_q;
    logic              ovf_q;
    wire  [STAGES-1:0] seg_carry;
    wire  [WIDTH-1:0]  result_bus;

    // Two-level lookahead over one segment: per-bit generate/propagate,
    // 4-bit group generate/propagate, then fully expanded group carries so
    // no carry ever ripples through more than one 4-bit group.
    // Returns {carry out of the segment, segment sum}.
    function automatic logic [SEG:0] cla_segment(
        input logic [SEG-1:0] a,
        input logic [SEG-1:0] b,
        input logic           cin
    );
        logic [SEG-1:0]  gen;
        logic [SEG-1:0]  prop;
        logic [SEG:0]    carry;
        logic [NGRP-1:0] grp_gen;
        logic [NGRP-1:0] grp_prop;
        logic [NGRP:0]   grp_carry;
        logic            acc;
        logic            chain;
        gen      = a & b;
        prop     = a ^ b;
        grp_gen  = '0;
        grp_prop = '0;
        for (int i = 0; i < SEG; i++) begin
            if (i % 4 == 0) begin
                grp_gen[i/4]  = gen[i];
                grp_prop[i/4] = prop[i];
            end else begin
                grp_gen[i/4]  = gen[i] | (prop[i] & grp_gen[i/4]);
                grp_prop[i/4] = prop[i] & grp_prop[i/4];
            end
        end
        grp_carry    = '0;
        grp_carry[0] = cin;
        for (int n = 1; n <= NGRP; n++) begin
            acc   = 1'b0;
            chain = 1'b1;
            for (int j = n - 1; j >= 0; j--) begin
                acc   = acc | (grp_gen[j] & chain);
                chain = chain & grp_prop[j];
            end
            grp_carry[n] = acc | (cin & chain);
        end
        carry = '0;
        for (int i = 0; i < SEG; i++) begin
            if (i % 4 == 0) begin
                carry[i] = grp_carry[i/4];
            end
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
        carry[SEG] = grp_carry[NGRP];
        return {carry[SEG], prop ^ carry[SEG-1:0]};
    endfunction

    assign op_sel = op_t'(op);

    // Decode the operation into the effective B operand and carry-in; bubbles
    // enter as all-zero so the datapath stays quiet when nothing is issued.
    always_comb begin
        a_eff = '0;
        b_eff = '0;
        c0    = 1'b0;
        if (in_valid) begin
            case (op_sel)
                OP_ADD: begin
                    a_eff = data_operandA;
                    b_eff = data_operandB;
                end
                OP_SUB: begin
                    a_eff = data_operandA;
                    b_eff = ~data_operandB;
                    c0    = 1'b1;
                end
                OP_PASS: begin
                    a_eff = data_operandA;
                end
                OP_ADC: begin
                    a_eff = data_operandA;
                    b_eff = data_operandB;
                    c0    = carry_in;
                end
                default: begin
                    a_eff = '0;
                end
            endcase
        end
    end

    // Valid bits shift alongside the data and freeze with the rest of the pipe.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else if (!stall) begin
            valid_q <= (valid_q << 1) | STAGES'(in_valid);
        end
    end

    for (genvar j = 0; j < STAGES; j++) begin : g_seg
        logic [SEG-1:0] op_a;
        logic [SEG-1:0] op_b;
        logic           seg_cin;
        logic [SEG:0]   seg_sum;
        logic           carry_q;
        logic [SEG-1:0] res_dly [STAGES-j];

        if (j == 0) begin : g_skew
            assign op_a = a_eff[SEG-1:0];
            assign op_b = b_eff[SEG-1:0];
        end else begin : g_skew
            logic [SEG-1:0] a_dly [j];
            logic [SEG-1:0] b_dly [j];

            // Hold this segment's operands back j cycles so they meet the
            // carry arriving from the segment below.
            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int d = 0; d < j; d++) begin
                        a_dly[d] <= '0;
                        b_dly[d] <= '0;
                    end
                end else if (!stall) begin
                    a_dly[0] <= a_eff[j*SEG +: SEG];
                    b_dly[0] <= b_eff[j*SEG +: SEG];
                    for (int d = 1; d < j; d++) begin
                        a_dly[d] <= a_dly[d-1];
                        b_dly[d] <= b_dly[d-1];
                    end
                end
            end

            assign op_a = a_dly[j-1];
            assign op_b = b_dly[j-1];
        end

        if (j == 0) begin : g_cin
            assign seg_cin = c0;
        end else begin : g_cin
            assign seg_cin = seg_carry[j-1];
        end

        assign seg_sum = cla_segment(op_a, op_b, seg_cin);

        // Register this segment's sum and carry, then delay the sum so it
        // leaves together with the upper segments of the same operation.
        always_ff @(posedge clock) begin
            if (reset) begin
                carry_q <= 1'b0;
                for (int d = 0; d < STAGES - j; d++) begin
                    res_dly[d] <= '0;
                end
            end else if (!stall) begin
                carry_q    <= seg_sum[SEG];
                res_dly[0] <= seg_sum[SEG-1:0];
                for (int d = 1; d < STAGES - j; d++) begin
                    res_dly[d] <= res_dly[d-1];
                end
            end
        end

        assign seg_carry[j]               = carry_q;
        assign result_bus[j*SEG +: SEG]   = res_dly[STAGES-1-j];

        if (j == STAGES - 1) begin : g_ovf
            // Signed overflow: both effective operands share a sign that the
            // sum does not; B is already inverted for subtraction here.
            always_ff @(posedge clock) begin
                if (reset) begin
                    ovf_q <= 1'b0;
                end else if (!stall) begin
                    ovf_q <= (op_a[SEG-1] == op_b[SEG-1]) &&
                             (seg_sum[SEG-1] != op_a[SEG-1]);
                end
            end
        end
    end

    assign data_result    = result_bus;
    assign carry_out      = seg_carry[STAGES-1];
    assign overflow       = ovf_q;
    assign data_resultRDY = valid_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed self-checking bench for pipelined_addsub at three geometries:
// 32-bit/4 stages, 16-bit/2 stages and 8-bit/1 stage.
module tb_pipelined_addsub;

    typedef struct packed {
        logic [1:0]  op;
        logic        ci;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        c;
        logic        o;
    } vec_t;

    typedef struct packed {
        logic        st;
        logic        v;
        logic [31:0] a;
        logic [31:0] b;
        logic        rdy;
        logic [31:0] res;
    } stall_t;

    logic clock;
    logic reset;

    logic        valid_32, stall_32, ci_32, c_32, o_32, rdy_32;
    logic [1:0]  op_32;
    logic [31:0] a_32, b_32, res_32;

    logic        valid_16, stall_16, ci_16, c_16, o_16, rdy_16;
    logic [1:0]  op_16;
    logic [15:0] a_16, b_16, res_16;

    logic        valid_8, stall_8, ci_8, c_8, o_8, rdy_8;
    logic [1:0]  op_8;
    logic [7:0]  a_8, b_8, res_8;

    int compared;
    int mismatched;

    vec_t   vec_tab [3][7];
    stall_t stall_tab [12];

    pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut_32 (
        .clock(clock), .reset(reset), .in_valid(valid_32), .stall(stall_32),
        .op(op_32), .carry_in(ci_32), .data_operandA(a_32), .data_operandB(b_32),
        .data_result(res_32), .carry_out(c_32), .overflow(o_32), .data_resultRDY(rdy_32)
    );

    pipelined_addsub #(.WIDTH(16), .STAGES(2)) dut_16 (
        .clock(clock), .reset(reset), .in_valid(valid_16), .stall(stall_16),
        .op(op_16), .carry_in(ci_16), .data_operandA(a_16), .data_operandB(b_16),
        .data_result(res_16), .carry_out(c_16), .overflow(o_16), .data_resultRDY(rdy_16)
    );

    pipelined_addsub #(.WIDTH(8), .STAGES(1)) dut_8 (
        .clock(clock), .reset(reset), .in_valid(valid_8), .stall(stall_8),
        .op(op_8), .carry_in(ci_8), .data_operandA(a_8), .data_operandB(b_8),
        .data_result(res_8), .carry_out(c_8), .overflow(o_8), .data_resultRDY(rdy_8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic applyStimulus(input int sel, input logic v, input logic st,
                                 input logic [1:0] o, input logic ci,
                                 input logic [31:0] a, input logic [31:0] b);
        case (sel)
            0: begin
                valid_32 = v; stall_32 = st; op_32 = o; ci_32 = ci; a_32 = a; b_32 = b;
            end
            1: begin
                valid_16 = v; stall_16 = st; op_16 = o; ci_16 = ci; a_16 = a[15:0]; b_16 = b[15:0];
            end
            default: begin
                valid_8 = v; stall_8 = st; op_8 = o; ci_8 = ci; a_8 = a[7:0]; b_8 = b[7:0];
            end
        endcase
    endtask

    task automatic checkOutput(input string tag, input int sel, input logic exp_rdy,
                               input logic chk_data, input logic [31:0] exp_res,
                               input logic exp_c, input logic exp_o);
        logic [31:0] got_res;
        logic        got_rdy, got_c, got_o;
        case (sel)
            0: begin
                got_res = res_32; got_rdy = rdy_32; got_c = c_32; got_o = o_32;
            end
            1: begin
                got_res = {16'h0, res_16}; got_rdy = rdy_16; got_c = c_16; got_o = o_16;
            end
            default: begin
                got_res = {24'h0, res_8}; got_rdy = rdy_8; got_c = c_8; got_o = o_8;
            end
        endcase
        compared++;
        assert (got_rdy === exp_rdy) else begin
            mismatched++;
            $error("[TB] FAIL %s rdy: got %b expected %b", tag, got_rdy, exp_rdy);
        end
        if (chk_data) begin
            compared++;
            assert (got_res === exp_res) else begin
                mismatched++;
                $error("[TB] FAIL %s result: got %h expected %h", tag, got_res, exp_res);
            end
            compared++;
            assert (got_c === exp_c) else begin
                mismatched++;
                $error("[TB] FAIL %s carry_out: got %b expected %b", tag, got_c, exp_c);
            end
            compared++;
            assert (got_o === exp_o) else begin
                mismatched++;
                $error("[TB] FAIL %s overflow: got %b expected %b", tag, got_o, exp_o);
            end
        end
    endtask

    initial begin
        int idx;
        int lat;
        compared   = 0;
        mismatched = 0;

        // 32-bit / 4 stages: {op, carry_in, A, B, result, carry_out, overflow}
        vec_tab[0][0] = '{2'b00, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
        vec_tab[0][1] = '{2'b01, 1'b0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1};
        vec_tab[0][2] = '{2'b01, 1'b0, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0};
        vec_tab[0][3] = '{2'b11, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
        vec_tab[0][4] = '{2'b10, 1'b0, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b0};
        vec_tab[0][5] = '{2'b00, 1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};
        vec_tab[0][6] = '{2'b01, 1'b1, 32'h0000000A, 32'h0000000A, 32'h00000000, 1'b1, 1'b0};
        // 16-bit / 2 stages
        vec_tab[1][0] = '{2'b00, 1'b0, 32'h7FFF, 32'h0001, 32'h8000, 1'b0, 1'b1};
        vec_tab[1][1] = '{2'b01, 1'b0, 32'h0000, 32'h0001, 32'hFFFF, 1'b0, 1'b0};
        vec_tab[1][2] = '{2'b11, 1'b1, 32'hFFFF, 32'hFFFF, 32'hFFFF, 1'b1, 1'b0};
        vec_tab[1][3] = '{2'b10, 1'b0, 32'hABCD, 32'h1234, 32'hABCD, 1'b0, 1'b0};
        vec_tab[1][4] = '{2'b00, 1'b0, 32'h00FF, 32'h0001, 32'h0100, 1'b0, 1'b0};
        vec_tab[1][5] = '{2'b01, 1'b0, 32'h8000, 32'h7FFF, 32'h0001, 1'b1, 1'b1};
        vec_tab[1][6] = '{2'b00, 1'b1, 32'h1234, 32'h4321, 32'h5555, 1'b0, 1'b0};
        // 8-bit / 1 stage
        vec_tab[2][0] = '{2'b00, 1'b0, 32'h7F, 32'h01, 32'h80, 1'b0, 1'b1};
        vec_tab[2][1] = '{2'b00, 1'b0, 32'hFF, 32'h01, 32'h00, 1'b1, 1'b0};
        vec_tab[2][2] = '{2'b01, 1'b0, 32'h03, 32'h05, 32'hFE, 1'b0, 1'b0};
        vec_tab[2][3] = '{2'b11, 1'b1, 32'h0F, 32'hF0, 32'h00, 1'b1, 1'b0};
        vec_tab[2][4] = '{2'b10, 1'b0, 32'h5A, 32'hFF, 32'h5A, 1'b0, 1'b0};
        vec_tab[2][5] = '{2'b01, 1'b0, 32'h80, 32'h01, 32'h7F, 1'b1, 1'b1};
        vec_tab[2][6] = '{2'b11, 1'b0, 32'h01, 32'h01, 32'h02, 1'b0, 1'b0};

        // Stall sequence on the 32-bit unit: {stall, in_valid, A, B, RDY, result}
        stall_tab[0]  = '{1'b0, 1'b1, 32'd1,   32'd1,   1'b0, 32'd0};
        stall_tab[1]  = '{1'b0, 1'b1, 32'd2,   32'd2,   1'b0, 32'd0};
        stall_tab[2]  = '{1'b1, 1'b1, 32'd100, 32'd100, 1'b0, 32'd0};
        stall_tab[3]  = '{1'b1, 1'b1, 32'd200, 32'd200, 1'b0, 32'd0};
        stall_tab[4]  = '{1'b0, 1'b1, 32'd3,   32'd3,   1'b0, 32'd0};
        stall_tab[5]  = '{1'b0, 1'b1, 32'd4,   32'd4,   1'b1, 32'd2};
        stall_tab[6]  = '{1'b0, 1'b0, 32'd0,   32'd0,   1'b1, 32'd4};
        stall_tab[7]  = '{1'b1, 1'b1, 32'd50,  32'd50,  1'b1, 32'd4};
        stall_tab[8]  = '{1'b0, 1'b0, 32'd0,   32'd0,   1'b1, 32'd6};
        stall_tab[9]  = '{1'b0, 1'b0, 32'd0,   32'd0,   1'b1, 32'd8};
        stall_tab[10] = '{1'b0, 1'b0, 32'd0,   32'd0,   1'b0, 32'd0};
        stall_tab[11] = '{1'b0, 1'b0, 32'd0,   32'd0,   1'b0, 32'd0};

        // Reset state
        reset = 1'b1;
        for (int s = 0; s < 3; s++) applyStimulus(s, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        for (int s = 0; s < 3; s++) checkOutput("reset state", s, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;

        // Back-to-back directed vectors, latency = STAGES
        for (int s = 0; s < 3; s++) begin
            lat = (s == 0) ? 4 : ((s == 1) ? 2 : 1);
            for (int t = 0; t < 7 + lat; t++) begin
                if (t < 7)
                    applyStimulus(s, 1'b1, 1'b0, vec_tab[s][t].op, vec_tab[s][t].ci,
                                  vec_tab[s][t].a, vec_tab[s][t].b);
                else
                    applyStimulus(s, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
                tick();
                idx = t + 1 - lat;
                if (idx >= 0 && idx < 7)
                    checkOutput($sformatf("vec%0d[%0d]", s, idx), s, 1'b1, 1'b1,
                                vec_tab[s][idx].res, vec_tab[s][idx].c, vec_tab[s][idx].o);
                else
                    checkOutput($sformatf("vec%0d idle t%0d", s, t), s, 1'b0, 1'b0,
                                32'h0, 1'b0, 1'b0);
            end
        end

        // Stall freezes the pipe and drops inputs offered meanwhile
        for (int t = 0; t < 12; t++) begin
            applyStimulus(0, stall_tab[t].v, stall_tab[t].st, 2'b00, 1'b0,
                          stall_tab[t].a, stall_tab[t].b);
            tick();
            checkOutput($sformatf("stall t%0d", t), 0, stall_tab[t].rdy, stall_tab[t].rdy,
                        stall_tab[t].res, 1'b0, 1'b0);
        end

        // Reset with operations in flight, coinciding with a new issue
        applyStimulus(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h7FFFFFFF, 32'h00000001);
        tick();
        checkOutput("flush pre0", 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h80000000, 32'h00000001);
        tick();
        checkOutput("flush pre1", 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'd30, 32'd30);
        tick();
        reset = 1'b0;
        checkOutput("flush reset edge", 0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        for (int t = 0; t < 5; t++) begin
            tick();
            checkOutput($sformatf("flush drain t%0d", t), 0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        end
        applyStimulus(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'd9, 32'd1);
        for (int t = 1; t <= 4; t++) begin
            tick();
            applyStimulus(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
            if (t < 4)
                checkOutput($sformatf("post-reset wait %0d", t), 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            else
                checkOutput("post-reset 9+1", 0, 1'b1, 1'b1, 32'd10, 1'b0, 1'b0);
        end
        tick();
        checkOutput("post-reset drained", 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
